// File: rtl/mirror_regs_axil_slave.sv
// AXI4-Lite responder holding the four 32-bit mirror control registers.
// Independent write/read FSMs; all outputs registered, update pulse per register.
module mirror_regs_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_out,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_out,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_out,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_out,
   output logic [3:0]                        reg_upd
);

   localparam int NumBytes = C_S_AXI_DATA_WIDTH / 8;

   typedef enum logic {WIdle, WResp} wstate_e;
   typedef enum logic {RIdle, RData} rstate_e;

   wstate_e                         r_wstate, w_wstate_nxt;
   rstate_e                         r_rstate, w_rstate_nxt;
   logic [C_S_AXI_DATA_WIDTH-1:0]   r_regs [4];
   logic                            r_awready, r_bvalid, r_arready, r_rvalid;
   logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;
   logic [3:0]                      r_upd;

   logic                            w_awready_nxt, w_bvalid_nxt, w_arready_nxt, w_rvalid_nxt;
   logic [3:0]                      w_upd_nxt;
   logic                            w_wr_hs, w_rd_hs;
   logic [1:0]                      w_wsel, w_rsel;
   logic                            w_unused;

   assign w_wsel   = s00_axi_awaddr[3:2];
   assign w_rsel   = s00_axi_araddr[3:2];
   // Ready is only ever raised in the idle state, so ready && valid is the handshake.
   assign w_wr_hs  = r_awready && s00_axi_awvalid && s00_axi_wvalid;
   assign w_rd_hs  = r_arready && s00_axi_arvalid;
   assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   // ---------------- write FSM ----------------
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) r_wstate <= WIdle;
      else                  r_wstate <= w_wstate_nxt;
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      unique case (r_wstate)
         WIdle:   if (w_wr_hs)        w_wstate_nxt = WResp;
         WResp:   if (s00_axi_bready) w_wstate_nxt = WIdle;
         default: w_wstate_nxt = WIdle;
      endcase
   end

   always_comb begin
      w_awready_nxt = (r_wstate == WIdle) && s00_axi_awvalid && s00_axi_wvalid && !r_awready;
      w_bvalid_nxt  = (r_wstate == WIdle) ? w_wr_hs : !s00_axi_bready;
      w_upd_nxt     = '0;
      if (w_wr_hs) w_upd_nxt[w_wsel] = 1'b1;
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
         r_upd     <= '0;
         for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      end else begin
         r_awready <= w_awready_nxt;
         r_bvalid  <= w_bvalid_nxt;
         r_upd     <= w_upd_nxt;
         if (w_wr_hs) begin
            for (int b = 0; b < NumBytes; b++) begin
               if (s00_axi_wstrb[b]) r_regs[w_wsel][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
            end
         end
      end
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) r_rstate <= RIdle;
      else                  r_rstate <= w_rstate_nxt;
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      unique case (r_rstate)
         RIdle:   if (w_rd_hs)        w_rstate_nxt = RData;
         RData:   if (s00_axi_rready) w_rstate_nxt = RIdle;
         default: w_rstate_nxt = RIdle;
      endcase
   end

   always_comb begin
      w_arready_nxt = (r_rstate == RIdle) && s00_axi_arvalid && !r_arready;
      w_rvalid_nxt  = (r_rstate == RIdle) ? w_rd_hs : !s00_axi_rready;
   end

   // rdata samples the register before any same-edge write lands.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_arready <= w_arready_nxt;
         r_rvalid  <= w_rvalid_nxt;
         if (w_rd_hs) r_rdata <= r_regs[w_rsel];
      end
   end

   assign s00_axi_awready = r_awready;
   assign s00_axi_wready  = r_awready;
   assign s00_axi_bvalid  = r_bvalid;
   assign s00_axi_bresp   = 2'b00;
   assign s00_axi_arready = r_arready;
   assign s00_axi_rvalid  = r_rvalid;
   assign s00_axi_rdata   = r_rdata;
   assign s00_axi_rresp   = 2'b00;
   assign reg0_out        = r_regs[0];
   assign reg1_out        = r_regs[1];
   assign reg2_out        = r_regs[2];
   assign reg3_out        = r_regs[3];
   assign reg_upd         = r_upd;

endmodule

// File: tb/tb_mirror_regs_axil_slave.sv
// Self-checking bench for mirror_regs_axil_slave: directed scenarios plus
// randomized traffic checked against an array-based register model.
module tb_mirror_regs_axil_slave;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [3:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;
   logic [3:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;
   logic [31:0] reg0_out, reg1_out, reg2_out, reg3_out;
   logic [3:0]  reg_upd;
   logic [31:0] dut_regs [4];

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] model [4];

   always #5 aclk = ~aclk;

   assign dut_regs[0] = reg0_out;
   assign dut_regs[1] = reg1_out;
   assign dut_regs[2] = reg2_out;
   assign dut_regs[3] = reg3_out;

   mirror_regs_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
      .s00_axi_aclk(aclk), .s00_axi_aresetn(aresetn),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
      .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
      .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
      .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
      .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
      .s00_axi_rready(rready), .reg0_out(reg0_out), .reg1_out(reg1_out),
      .reg2_out(reg2_out), .reg3_out(reg3_out), .reg_upd(reg_upd)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = nw[8*k +: 8];
      return r;
   endfunction

   // Full write with bready high; returns response, pulse seen and timeout flag.
   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output logic [3:0] upd, output bit to);
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      to = 1'b1; resp = 2'bxx; upd = 'x;
      for (int i = 0; i < 20; i++) begin
         @(posedge aclk); #1;
         if (awready && wready) begin to = 1'b0; break; end
      end
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      if (!to) begin
         resp = bresp; upd = reg_upd; to = !bvalid;
         @(posedge aclk); #1;
      end
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit to);
      araddr = addr; arvalid = 1'b1; to = 1'b1; data = 'x; resp = 2'bxx;
      for (int i = 0; i < 20; i++) begin
         @(posedge aclk); #1;
         if (arready) begin to = 1'b0; break; end
      end
      @(posedge aclk); #1;
      arvalid = 1'b0;
      if (!to) begin
         data = rdata; resp = rresp; to = !rvalid;
         @(posedge aclk); #1;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r; bit to;
      aresetn = 1'b0;
      #500;
      n_checks++;
      if ({awready, wready, bvalid, arready, rvalid, rdata, reg_upd} !== '0) begin
         n_fail++; $display("FAIL reset_hold: outputs nonzero rdata=%h upd=%b", rdata, reg_upd);
      end
      @(posedge aclk); #1 aresetn = 1'b1;
      for (int i = 0; i < 4; i++) model[i] = '0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (dut_regs[i] !== 32'h0) begin
            n_fail++; $display("FAIL reset_reg%0d: got %h want 0", i, dut_regs[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(i * 4), d, r, to);
         n_checks++;
         if (to || d !== 32'h0 || r !== 2'b00) begin
            n_fail++; $display("FAIL reset_read%0d: got %h/%b to=%0d want 0/00", i, d, r, to);
         end
      end
   endtask

   task automatic test_sweep();
      logic [31:0] vals [4];
      logic [31:0] d; logic [1:0] r; logic [3:0] u; bit to;
      vals[0] = 32'h0101FFFF; vals[1] = 32'hABCD0001;
      vals[2] = 32'hDEAD0011; vals[3] = 32'hBEEF0011;
      for (int i = 0; i < 4; i++) begin
         axi_write(4'(i * 4), vals[i], 4'hF, r, u, to);
         model[i] = vals[i];
         n_checks++;
         if (to || r !== 2'b00 || u !== 4'(1 << i)) begin
            n_fail++; $display("FAIL sweep_wr%0d: resp=%b upd=%b to=%0d want 00/%b", i, r, u, to,
                               4'(1 << i));
         end
         n_checks++;
         if (dut_regs[i] !== vals[i]) begin
            n_fail++; $display("FAIL sweep_out%0d: got %h want %h", i, dut_regs[i], vals[i]);
         end
         axi_read(4'(i * 4), d, r, to);
         n_checks++;
         if (to || d !== vals[i] || r !== 2'b00) begin
            n_fail++; $display("FAIL sweep_rd%0d: got %h/%b want %h/00", i, d, r, vals[i]);
         end
      end
   endtask

   task automatic test_strobe();
      logic [1:0] r; logic [3:0] u; bit to;
      axi_write(4'h4, 32'h11223344, 4'b0101, r, u, to);
      model[1] = merge(model[1], 32'h11223344, 4'b0101);
      n_checks++;
      if (to || reg1_out !== 32'hAB220044 || u !== 4'b0010) begin
         n_fail++; $display("FAIL strobe: reg1=%h upd=%b want ab220044/0010", reg1_out, u);
      end
      axi_write(4'h8, 32'hFFFFFFFF, 4'b0000, r, u, to);
      n_checks++;
      if (to || r !== 2'b00 || u !== 4'b0100 || reg2_out !== model[2]) begin
         n_fail++; $display("FAIL strobe_zero: reg2=%h upd=%b want %h/0100", reg2_out, u, model[2]);
      end
   endtask

   task automatic test_random();
      logic [31:0] d; logic [1:0] r; logic [3:0] u, a, s; bit to;
      for (int n = 0; n < 60; n++) begin
         a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom; s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, r, u, to);
            model[a[3:2]] = merge(model[a[3:2]], d, s);
            n_checks++;
            if (to || r !== 2'b00 || u !== 4'(1 << a[3:2])) begin
               n_fail++; $display("FAIL rand_wr%0d: resp=%b upd=%b to=%0d addr=%h", n, r, u, to, a);
            end
            for (int i = 0; i < 4; i++) begin
               n_checks++;
               if (dut_regs[i] !== model[i]) begin
                  n_fail++; $display("FAIL rand_out%0d_%0d: got %h want %h", n, i, dut_regs[i],
                                     model[i]);
               end
            end
         end else begin
            axi_read(a, d, r, to);
            n_checks++;
            if (to || d !== model[a[3:2]] || r !== 2'b00) begin
               n_fail++; $display("FAIL rand_rd%0d: addr=%h got %h want %h", n, a, d, model[a[3:2]]);
            end
         end
      end
   endtask

   task automatic test_skew();
      logic [1:0] r; logic [3:0] u; bit to;
      awaddr = 4'hC; awvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge aclk); #1;
         n_checks++;
         if (awready !== 1'b0 || wready !== 1'b0) begin
            n_fail++; $display("FAIL skew_hold%0d: awready=%b wready=%b want 0", i, awready, wready);
         end
      end
      axi_write(4'hC, 32'h5A5AA5A5, 4'hF, r, u, to);
      model[3] = 32'h5A5AA5A5;
      n_checks++;
      if (to || reg3_out !== model[3] || u !== 4'b1000) begin
         n_fail++; $display("FAIL skew_wr: reg3=%h upd=%b want %h/1000", reg3_out, u, model[3]);
      end
   endtask

   task automatic test_bp_write();
      bit to;
      bready = 1'b0;
      awaddr = 4'h0; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      to = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge aclk); #1;
         if (awready) begin to = 1'b0; break; end
      end
      @(posedge aclk); #1;
      model[0] = 32'hCAFEF00D;
      wdata = 32'h600DBEEF;  // second write held off while B is pending
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (to || bvalid !== 1'b1 || awready !== 1'b0 || reg0_out !== model[0]) begin
            n_fail++; $display("FAIL bp_hold%0d: bvalid=%b awready=%b reg0=%h want 1/0/%h", i,
                               bvalid, awready, reg0_out, model[0]);
         end
         @(posedge aclk); #1;
      end
      bready = 1'b1;
      @(posedge aclk); #1;
      n_checks++;
      if (bvalid !== 1'b0) begin
         n_fail++; $display("FAIL bp_release: bvalid=%b want 0", bvalid);
      end
      to = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (awready) begin to = 1'b0; break; end
         @(posedge aclk); #1;
      end
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      model[0] = 32'h600DBEEF;
      n_checks++;
      if (to || bvalid !== 1'b1 || reg0_out !== model[0]) begin
         n_fail++; $display("FAIL bp_second: bvalid=%b reg0=%h want 1/%h", bvalid, reg0_out, model[0]);
      end
      @(posedge aclk); #1;
   endtask

   task automatic test_bp_read();
      logic [31:0] d0; logic [1:0] r; logic [3:0] u; bit to;
      rready = 1'b0;
      araddr = 4'h4; arvalid = 1'b1; to = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge aclk); #1;
         if (arready) begin to = 1'b0; break; end
      end
      @(posedge aclk); #1;
      arvalid = 1'b0;
      d0 = rdata;
      n_checks++;
      if (to || rvalid !== 1'b1 || d0 !== model[1]) begin
         n_fail++; $display("FAIL bp_rd_first: rvalid=%b rdata=%h want 1/%h", rvalid, d0, model[1]);
      end
      axi_write(4'h4, ~model[1], 4'hF, r, u, to);
      n_checks++;
      if (to || rvalid !== 1'b1 || rdata !== model[1]) begin
         n_fail++; $display("FAIL bp_rd_stable: rvalid=%b rdata=%h want 1/%h", rvalid, rdata,
                            model[1]);
      end
      model[1] = ~model[1];
      rready = 1'b1;
      @(posedge aclk); #1;
      n_checks++;
      if (rvalid !== 1'b0) begin
         n_fail++; $display("FAIL bp_rd_release: rvalid=%b want 0", rvalid);
      end
   endtask

   task automatic test_collision();
      logic [1:0] r; logic [3:0] u; bit to;
      axi_write(4'h8, 32'hDEAD0011, 4'hF, r, u, to);
      awaddr = 4'h8; wdata = 32'h12345678; wstrb = 4'hF; araddr = 4'h8;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; to = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge aclk); #1;
         if (awready && arready) begin to = 1'b0; break; end
      end
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      model[2] = 32'h12345678;
      n_checks++;
      if (to || rvalid !== 1'b1 || rdata !== 32'hDEAD0011 || reg2_out !== 32'h12345678) begin
         n_fail++; $display("FAIL collision: rdata=%h reg2=%h want dead0011/12345678", rdata,
                            reg2_out);
      end
      @(posedge aclk); #1;
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic [1:0] r; bit to;
      bready = 1'b0; rready = 1'b0;
      awaddr = 4'h4; wdata = 32'h77777777; wstrb = 4'hF; araddr = 4'h4;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      n_checks++;
      if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_pre: bvalid=%b rvalid=%b want 1/1", bvalid, rvalid);
      end
      #2 aresetn = 1'b0;
      #1;
      n_checks++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0 || reg_upd !== 4'b0 || rdata !== 32'h0) begin
         n_fail++; $display("FAIL rstmid_async: bvalid=%b rvalid=%b upd=%b rdata=%h want 0",
                            bvalid, rvalid, reg_upd, rdata);
      end
      for (int i = 0; i < 4; i++) model[i] = '0;
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
      bready = 1'b1; rready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge aclk); #1;
         n_checks++;
         if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_stale%0d: bvalid=%b rvalid=%b want 0", i, bvalid, rvalid);
         end
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(i * 4), d, r, to);
         n_checks++;
         if (to || d !== model[i] || dut_regs[i] !== model[i]) begin
            n_fail++; $display("FAIL rstmid_rd%0d: got %h out=%h want 0", i, d, dut_regs[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_strobe();
      test_random();
      test_skew();
      test_bp_write();
      test_bp_read();
      test_collision();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mirror_regs_axil_slave.md
# mirror_regs_axil_slave

AXI4-Lite responder that holds the four 32-bit control registers of the mirror driver and exports them to the mirror datapath. It sits behind the interconnect on the S00_AXI port and is the endpoint that the block-design AXI4-Lite master BFM writes and reads. Every register bit is read/write, and a read returns exactly the last value written. A per-register update pulse tells downstream logic when a new value has landed.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; 4 registers at offsets 0x0/0x4/0x8/0xC.

Ports:
- s00_axi_aclk  in  1  single clock; all logic on rising edge.
- s00_axi_aresetn  in  1  reset, asynchronous assert, active-low.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  write address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  write data handshake.
- s00_axi_bresp  out  2  always 2'b00 (OKAY).
- s00_axi_bvalid / s00_axi_bready  out / in  1  write response handshake.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  read address handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  always 2'b00 (OKAY).
- s00_axi_rvalid / s00_axi_rready  out / in  1  read data handshake.
- reg0_out..reg3_out  out  32 each  current register contents.
- reg_upd  out  4  one-cycle pulse; bit n is high the cycle after register n is written.

## Operation
- Register decode uses address bits [3:2]. Bits [1:0] and bits above [3] are ignored.
- Write path is a two-state FSM.
  - W_IDLE: when awvalid && wvalid && !awready, assert awready and wready together for exactly one cycle.
  - On that handshake edge, the register selected by awaddr[3:2] is updated byte-wise: byte k takes wdata[8k+7:8k] where wstrb[k]=1 and keeps its value otherwise. In the same edge, reg_upd[sel] is set and the FSM enters W_RESP with bvalid=1.
  - A write with wstrb=0 still completes with OKAY and still pulses reg_upd.
  - W_RESP: bvalid stays high until bready. On the edge where bvalid && bready, bvalid clears and the FSM returns to W_IDLE. No new AW/W is accepted while in W_RESP.
  - AW arriving without W, or W without AW, is held off (ready stays low) until both are valid.
- Read path is a two-state FSM.
  - R_IDLE: when arvalid && !arready, assert arready for one cycle. On that edge, rdata is loaded from the register selected by araddr[3:2] and rvalid is set.
  - R_DATA: rvalid and rdata hold stable until rready. On the edge where rvalid && rready, rvalid clears and the FSM returns to R_IDLE.
- The read and write FSMs are independent and may run concurrently.
- Read and write handshakes on the same edge to the same register: rdata returns the pre-write value.
- No error responses are ever generated; bresp and rresp are tied to OKAY.

## Timing
- Reset values (while s00_axi_aresetn=0, effective immediately): all registers 0, all ready/valid outputs 0, rdata 0, reg_upd 0, both FSMs idle.
- Reset asserted mid-transaction abandons it. No response is issued after reset, and the registers clear.
- Write latency: awvalid and wvalid high at edge N means awready/wready are high in cycle N+1 and the register is updated at edge N+1. From edge N+1, bvalid is high, reg_upd pulses for that single cycle, and regN_out shows the new value.
- Minimum write throughput is one write per 3 cycles with bready tied high.
- Read latency: arvalid high at edge N means arready is high in cycle N+1. From edge N+1, rvalid and rdata are valid.
- Minimum read throughput is one read per 3 cycles with rready tied high.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold aresetn=0 for 500 ns, then release at a rising clock edge -> every output reads 0. Then read offsets 0x0..0xC -> rdata=0x00000000 with rresp=OKAY for each.
- Write/read-back sweep: write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to offsets 0x0/0x4/0x8/0xC, each followed by a read of the same offset -> bresp and rresp OKAY, rdata equals the written value, reg_upd pulses bits 0,1,2,3 in turn.
- Byte strobe: with reg1=0xABCD0001, write 0x11223344 to 0x4 with wstrb=4'b0101 -> reg1_out=0xAB220044.
- Handshake skew and backpressure:
  - Present AW 3 cycles before W -> awready stays 0 until W arrives.
  - Hold bready=0 for 5 cycles -> bvalid stays 1 and a second AW/W is not accepted.
  - Hold rready=0 -> rdata stays stable.
- Read/write collision: reg2=0xDEAD0011; on the same edge, write 0x12345678 to 0x8 and read 0x8 -> rdata=0xDEAD0011, reg2_out=0x12345678.
- Reset mid-transaction: assert aresetn=0 while bvalid=1 -> bvalid drops immediately, all registers read 0 after reset is released, and no stale B or R response appears.
